// File: rtl/binary_to_bcd_conv.sv
// Binary nibble to two-digit BCD converter with a digit-validity flag.
// Inputs 0..9 pass through as the ones digit; 10..15 are flagged invalid
// and both digits are forced to zero. The tens digit is always zero here
// and is kept 4 bits wide so wider BCD stages can share the interface.
module binary_to_bcd_conv #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid
);

  logic [3:0] conv_tens;
  logic [3:0] conv_ones;
  logic       conv_valid;

  // Convert the current bin into digits; anything above 9 is rejected.
  always_comb begin
    conv_tens  = 4'h0;
    conv_ones  = 4'h0;
    conv_valid = 1'b0;
    if (bin <= 4'd9) begin
      conv_ones  = bin;
      conv_valid = 1'b1;
    end
  end

  generate
    if (OUT_REG) begin : g_reg
      // Register the conversion; a low rst_n at the edge clears everything.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          tens  <= 4'h0;
          ones  <= 4'h0;
          valid <= 1'b0;
        end else begin
          tens  <= conv_tens;
          ones  <= conv_ones;
          valid <= conv_valid;
        end
      end
    end else begin : g_comb
      // Clock and reset play no part in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      // Outputs follow bin directly.
      always_comb begin
        tens  = conv_tens;
        ones  = conv_ones;
        valid = conv_valid;
      end
    end
  endgenerate

endmodule

// File: tb/tb_binary_to_bcd_conv.sv
// Self-checking bench for binary_to_bcd_conv: registered and
// combinational builds checked against a decimal-arithmetic reference.
module tb_binary_to_bcd_conv;

  logic       clk;
  logic       rst_n;
  logic [3:0] bin;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       valid;
  logic [3:0] comb_tens;
  logic [3:0] comb_ones;
  logic       comb_valid;

  int vectors;
  int miscompares;

  binary_to_bcd_conv #(.OUT_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (bin),
    .tens  (tens),
    .ones  (ones),
    .valid (valid)
  );

  binary_to_bcd_conv #(.OUT_REG(1'b0)) dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (bin),
    .tens  (comb_tens),
    .ones  (comb_ones),
    .valid (comb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a decimal digit 0..9 splits into tens/ones by plain
  // division; anything else, or reset, yields all zeros.
  function automatic logic [8:0] model(input int value, input bit in_reset);
    logic [3:0] t;
    logic [3:0] o;
    if (in_reset || value < 0 || value > 9) return 9'h000;
    t = 4'(value / 10);
    o = 4'(value % 10);
    return {t, o, 1'b1};
  endfunction

  task automatic checkOutput(input string tag, input logic [8:0] observed,
                             input logic [8:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed tens/ones/valid=%h/%h/%b expected %h/%h/%b",
             tag, observed[8:5], observed[4:1], observed[0],
             expected[8:5], expected[4:1], expected[0]);
    end
  endtask

  // Drive one input set between edges, then check both builds after the edge.
  task automatic applyStimulus(input string tag, input logic [3:0] b,
                               input logic r);
    @(negedge clk);
    bin   = b;
    rst_n = r;
    @(posedge clk);
    #1;
    checkOutput(tag, {tens, ones, valid}, model(int'(b), !r));
    checkOutput({tag, "_comb"}, {comb_tens, comb_ones, comb_valid},
                model(int'(b), 1'b0));
  endtask

  initial begin
    logic [3:0] rb;
    logic       rr;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bin         = 4'h7;

    // Reset held for two edges with bin = 7, then release.
    applyStimulus("reset0", 4'h7, 1'b0);
    applyStimulus("reset1", 4'h7, 1'b0);
    applyStimulus("release", 4'h7, 1'b1);

    // Sweep valid then invalid inputs.
    for (int i = 0; i < 16; i++)
      applyStimulus($sformatf("sweep%0d", i), 4'(i), 1'b1);

    // Boundary 9 -> 10 -> 0.
    applyStimulus("bound9", 4'd9, 1'b1);
    applyStimulus("bound10", 4'd10, 1'b1);
    applyStimulus("bound0", 4'd0, 1'b1);

    // Synchronous reset dropped mid-cycle must not act until the edge.
    applyStimulus("run5", 4'd5, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset_hold", {tens, ones, valid}, model(5, 1'b0));
    @(posedge clk);
    #1;
    checkOutput("midreset_edge", {tens, ones, valid}, model(5, 1'b1));
    applyStimulus("reset_wins", 4'd3, 1'b0);
    applyStimulus("post_reset", 4'd8, 1'b1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 60; i++) begin
      rb = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 7) != 0);
      applyStimulus($sformatf("rand%0d", i), rb, rr);
    end

    // Combinational build settles within 10 ns without needing a clock edge.
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bin = 4'(i);
      #10;
      checkOutput($sformatf("comb%0d", i), {comb_tens, comb_ones, comb_valid},
                  model(i, 1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
